// File: rtl/uart_rx_oversampled.sv
// UART receiver, 16x oversampled, LSB-first frames with optional even parity.
// Emits one rx_done_tick per completed frame along with frame/parity error flags.
module uart_rx_oversampled #(
    parameter int DBIT      = 8,
    parameter int SB_TICK   = 16,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);

    // Tick counter widens so 1.5 and 2 stop-bit settings still fit.
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state, state_nx;
    logic [SW-1:0]   s, s_nx;
    logic [2:0]      n, n_nx;
    logic [DBIT-1:0] shift, shift_nx;
    logic [DBIT-1:0] dout_nx;
    logic            perr, perr_nx;
    logic            ferr_nx, pe_nx, done_nx;
    logic [1:0]      sync;
    logic            rx_s;

    assign rx_s = sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync         <= 2'b11;
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            shift        <= '0;
            perr         <= 1'b0;
            dout         <= '0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
            rx_done_tick <= 1'b0;
        end else begin
            sync         <= {sync[0], rx};
            state        <= state_nx;
            s            <= s_nx;
            n            <= n_nx;
            shift        <= shift_nx;
            perr         <= perr_nx;
            dout         <= dout_nx;
            frame_err    <= ferr_nx;
            parity_err   <= pe_nx;
            rx_done_tick <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        s_nx     = s;
        n_nx     = n;
        shift_nx = shift;
        perr_nx  = perr;
        dout_nx  = dout;
        ferr_nx  = frame_err;
        pe_nx    = parity_err;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    s_nx     = '0;
                    perr_nx  = 1'b0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == SW'(7)) begin
                        // A start bit that is gone by mid-bit was a glitch.
                        if (!rx_s) begin
                            state_nx = DATA;
                            s_nx     = '0;
                            n_nx     = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        s_nx = s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == SW'(15)) begin
                        s_nx     = '0;
                        shift_nx = {rx_s, shift[DBIT-1:1]};
                        if (n == 3'(DBIT - 1)) begin
                            if (PARITY_EN) state_nx = PARITY;
                            else           state_nx = STOP;
                        end else begin
                            n_nx = n + 3'd1;
                        end
                    end else begin
                        s_nx = s + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s == SW'(15)) begin
                        s_nx     = '0;
                        perr_nx  = rx_s ^ (^shift);
                        state_nx = STOP;
                    end else begin
                        s_nx = s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == SW'(SB_TICK - 1)) begin
                        state_nx = IDLE;
                        dout_nx  = shift;
                        ferr_nx  = ~rx_s;
                        pe_nx    = perr;
                        done_nx  = 1'b1;
                    end else begin
                        s_nx = s + SW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
